// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU classes, funct codes, ALU control
// codes, the MDU state type and the control half of the EX/MEM register.
package ex_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_SLL  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLTU = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_MFHI = 4'hA;
  localparam logic [3:0] ALU_MFLO = 4'hB;
  localparam logic [3:0] ALU_NOR  = 4'hC;
  localparam logic [3:0] ALU_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Datapath fields are XLEN-wide and live beside this struct in the top.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic zero;
  } ex_mem_t;

  function automatic logic [3:0] alu_ctrl(input logic [2:0] op, input logic [5:0] funct);
    logic [3:0] sel;
    sel = ALU_ADD;
    case (op)
      ALUOP_SUB: sel = ALU_SUB;
      ALUOP_AND: sel = ALU_AND;
      ALUOP_OR:  sel = ALU_OR;
      ALUOP_SLT: sel = ALU_SLT;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: sel = ALU_ADD;
          F_SUB, F_SUBU: sel = ALU_SUB;
          F_AND:         sel = ALU_AND;
          F_OR:          sel = ALU_OR;
          F_XOR:         sel = ALU_XOR;
          F_NOR:         sel = ALU_NOR;
          F_SLT:         sel = ALU_SLT;
          F_SLTU:        sel = ALU_SLTU;
          F_SLL:         sel = ALU_SLL;
          F_SRL:         sel = ALU_SRL;
          F_SRA:         sel = ALU_SRA;
          F_MFHI:        sel = ALU_MFHI;
          F_MFLO:        sel = ALU_MFLO;
          default:       sel = ALU_NONE;
        endcase
      end
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ex_mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO. Divider datapath only exists
// when EX_MDU_DIV_EN is defined; otherwise only the shift-add multiplier is built.
//   state | meaning
//   IDLE  | waiting for start
//   BUSY  | one shift-add / restoring-subtract step per cycle
//   DONE  | result ready, HI/LO written when the output register can take it
module ex_mdu_iter import ex_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            drain,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN + 1);

  mdu_state_t        state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   acc_hi, acc_lo, opnd;
  logic              neg_res;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     step_sum;
  logic [XLEN-1:0]   step_hi, step_lo, res_hi, res_lo;
  logic [2*XLEN-1:0] prod;
`ifdef EX_MDU_DIV_EN
  logic              neg_rem, div_op, div_zero;
  logic [XLEN:0]     shifted, diff;
`else
  logic              unused_div_sel;
  assign unused_div_sel = op[1];
`endif

  // op = {divide, signed}; signed ops run on magnitudes
  assign sa    = op[0] & a[XLEN-1];
  assign sb    = op[0] & b[XLEN-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;
  assign busy  = (state == BUSY);
  assign done  = (state == DONE);

  always_comb begin
    step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    step_hi  = step_sum[XLEN:1];
    step_lo  = {step_sum[0], acc_lo[XLEN-1:1]};
    prod     = {acc_hi, acc_lo};
    if (neg_res) prod = -prod;
    res_hi   = prod[2*XLEN-1:XLEN];
    res_lo   = prod[XLEN-1:0];
`ifdef EX_MDU_DIV_EN
    shifted  = {acc_hi, acc_lo[XLEN-1]};
    diff     = shifted - {1'b0, opnd};
    if (div_op) begin
      step_hi = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], ~diff[XLEN]};
      res_lo  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
      res_hi  = neg_rem ? -acc_hi : acc_hi;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef EX_MDU_DIV_EN
      neg_rem  <= 1'b0;
      div_op   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= BUSY;
          cnt     <= CW'(XLEN);
          acc_hi  <= '0;
          neg_res <= sa ^ sb;
`ifdef EX_MDU_DIV_EN
          opnd     <= op[1] ? b_mag : a_mag;
          acc_lo   <= op[1] ? a_mag : b_mag;
          neg_rem  <= sa;
          div_op   <= op[1];
          div_zero <= (b == '0);
`else
          opnd   <= a_mag;
          acc_lo <= b_mag;
`endif
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: if (drain) begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage with EX/MEM output register, valid/ready on both sides and an
// iterative MDU. Define EX_MDU_DIV_EN to execute div/divu; otherwise they retire as no-ops.
module ex_stage_pipe import ex_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            reg_write,
  input  logic            mem_to_reg,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            alu_src,
  input  logic            reg_dest,
  input  logic [2:0]      alu_op,
  input  logic [XLEN-1:0] pc_4,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] sign_extend,
  input  logic [RA_W-1:0] rt,
  input  logic [RA_W-1:0] rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [RA_W-1:0] dest_reg,
  output logic            zero,
  output logic            reg_write_o,
  output logic            mem_to_reg_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            mdu_busy
);
  logic [5:0]      funct;
  logic [4:0]      shamt;
  logic [3:0]      alu_sel;
  logic            is_rtype, is_mult, is_div, is_mfx, mdu_req, kill_ctrl;
  logic            hazard, drain, accept, mdu_start, mdu_done, done_load;
  logic [XLEN-1:0] hi, lo, b_op, alu_y, br_y;
  ex_mem_t         new_ctrl, ctrl_q;
  logic            valid_q, pend_zero;
  logic [XLEN-1:0] br_q, alu_q, st_q, pend_br, pend_alu, pend_st;
  logic [RA_W-1:0] dst_q, pend_dst, dst_y;

  assign funct    = sign_extend[5:0];
  assign shamt    = sign_extend[10:6];
  assign alu_sel  = alu_ctrl(alu_op, funct);
  assign is_rtype = (alu_op == ALUOP_RTYPE);
  assign is_mult  = is_rtype && (funct == F_MULT || funct == F_MULTU);
  assign is_div   = is_rtype && (funct == F_DIV || funct == F_DIVU);
  assign is_mfx   = is_rtype && (funct == F_MFHI || funct == F_MFLO);
`ifdef EX_MDU_DIV_EN
  assign mdu_req   = is_mult || is_div;
  assign kill_ctrl = 1'b0;
`else
  assign mdu_req   = is_mult;
  assign kill_ctrl = is_div;
`endif

  assign hazard    = is_mfx && mdu_busy;
  assign drain     = !valid_q || out_ready;
  assign in_ready  = !mdu_busy && !mdu_done && drain && !hazard;
  assign accept    = in_valid && in_ready;
  assign mdu_start = accept && mdu_req && !flush;
  assign done_load = mdu_done && drain;

  assign b_op  = alu_src ? sign_extend : data2;
  assign br_y  = pc_4 + (sign_extend << 2);
  assign dst_y = reg_dest ? rd : rt;

  always_comb begin
    alu_y = '0;
    case (alu_sel)
      ALU_AND:  alu_y = data1 & b_op;
      ALU_OR:   alu_y = data1 | b_op;
      ALU_ADD:  alu_y = data1 + b_op;
      ALU_SUB:  alu_y = data1 - b_op;
      ALU_XOR:  alu_y = data1 ^ b_op;
      ALU_NOR:  alu_y = ~(data1 | b_op);
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(b_op))};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (data1 < b_op)};
      ALU_SLL:  alu_y = b_op << shamt;
      ALU_SRL:  alu_y = b_op >> shamt;
      ALU_SRA:  alu_y = $signed(b_op) >>> shamt;
      ALU_MFHI: alu_y = hi;
      ALU_MFLO: alu_y = lo;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    new_ctrl.reg_write  = reg_write  & ~kill_ctrl;
    new_ctrl.mem_to_reg = mem_to_reg & ~kill_ctrl;
    new_ctrl.mem_read   = mem_read   & ~kill_ctrl;
    new_ctrl.mem_write  = mem_write  & ~kill_ctrl;
    new_ctrl.branch     = branch     & ~kill_ctrl;
    new_ctrl.zero       = (alu_y == '0);
  end

  ex_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start),
    .op    ({funct[1], ~funct[0]}),
    .a     (data1),
    .b     (data2),
    .flush (flush),
    .drain (drain),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .hi    (hi),
    .lo    (lo)
  );

  // The MDU instruction's own fields are parked here until it retires at DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_br   <= '0;
      pend_alu  <= '0;
      pend_st   <= '0;
      pend_dst  <= '0;
      pend_zero <= 1'b0;
    end else if (mdu_start) begin
      pend_br   <= br_y;
      pend_alu  <= alu_y;
      pend_st   <= data2;
      pend_dst  <= dst_y;
      pend_zero <= new_ctrl.zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      br_q    <= '0;
      alu_q   <= '0;
      st_q    <= '0;
      dst_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '{zero: ctrl_q.zero, default: 1'b0};
    end else if (accept && !mdu_req) begin
      valid_q <= 1'b1;
      ctrl_q  <= new_ctrl;
      br_q    <= br_y;
      alu_q   <= alu_y;
      st_q    <= data2;
      dst_q   <= dst_y;
    end else if (done_load) begin
      valid_q <= 1'b1;
      ctrl_q  <= '{zero: pend_zero, default: 1'b0};
      br_q    <= pend_br;
      alu_q   <= pend_alu;
      st_q    <= pend_st;
      dst_q   <= pend_dst;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign br_target    = br_q;
  assign alu_result   = alu_q;
  assign store_data   = st_q;
  assign dest_reg     = dst_q;
  assign zero         = ctrl_q.zero;
  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign branch_o     = ctrl_q.branch;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: ALU paths, MDU timing/results, stalls, flush and reset.
module tb_ex_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic        reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dest;
  logic [2:0]  alu_op;
  logic [31:0] pc_4, data1, data2, sign_extend;
  logic [4:0]  rt, rd;
  logic        out_valid, out_ready;
  logic [31:0] br_target, alu_result, store_data;
  logic [4:0]  dest_reg;
  logic        zero, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o, mdu_busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi, exp_lo;

  ex_stage_pipe #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .alu_src(alu_src), .reg_dest(reg_dest),
    .alu_op(alu_op), .pc_4(pc_4), .data1(data1), .data2(data2),
    .sign_extend(sign_extend), .rt(rt), .rd(rd), .out_valid(out_valid),
    .out_ready(out_ready), .br_target(br_target), .alu_result(alu_result),
    .store_data(store_data), .dest_reg(dest_reg), .zero(zero),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_r(input logic [31:0] se, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
    alu_op = 3'b010; sign_extend = se; data1 = a; data2 = b; rd = d; rt = 5'd0;
    reg_dest = 1'b1; reg_write = 1'b1; alu_src = 1'b0; branch = 1'b0;
    mem_to_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0; in_valid = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      n++;
      tick();
    end
    chk(tag, 32'(in_ready), 1);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] f, input logic [31:0] exp);
    drive_r({26'd0, f}, 32'd0, 32'd0, 5'd1);
    tick();
    chk(tag, alu_result, exp);
    in_valid = 1'b0;
  endtask

  task automatic mdu_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    drive_r({26'd0, f}, a, b, 5'd4);
    tick();
    in_valid = 1'b0;
    wait_ready("mdu_ready");
  endtask

  initial begin
    int n, nb;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    reg_write = 0; mem_to_reg = 0; mem_read = 0; mem_write = 0; branch = 0;
    alu_src = 0; reg_dest = 0; alu_op = 3'b000; pc_4 = 0; data1 = 0; data2 = 0;
    sign_extend = 0; rt = 0; rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_alu_result", alu_result, 0);
    chk("rst_br_target", br_target, 0);
    chk("rst_store_data", store_data, 0);
    chk("rst_dest_reg", 32'(dest_reg), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_reg_write_o", 32'(reg_write_o), 0);
    chk("rst_mdu_busy", 32'(mdu_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // add 5+7 -> rd 3
    drive_r(32'h20, 32'd5, 32'd7, 5'd3);
    rt = 5'd9;
    tick();
    chk("add_result", alu_result, 12);
    chk("add_dest", 32'(dest_reg), 3);
    chk("add_zero", 32'(zero), 0);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_rw", 32'(reg_write_o), 1);

    // beq with equal operands
    alu_op = 3'b001; data1 = 32'h55; data2 = 32'h55; pc_4 = 32'h100; sign_extend = 32'd4;
    branch = 1'b1; reg_write = 1'b0;
    tick();
    chk("beq_target", br_target, 32'h110);
    chk("beq_zero", 32'(zero), 1);
    chk("beq_branch", 32'(branch_o), 1);

    // addi with negative immediate; target wraps below pc_4
    alu_op = 3'b000; alu_src = 1'b1; data1 = 32'd10; sign_extend = 32'hFFFF_FFFF;
    pc_4 = 32'h200; branch = 1'b0; reg_dest = 1'b0; rt = 5'd9; reg_write = 1'b1;
    tick();
    chk("addi_result", alu_result, 9);
    chk("addi_target", br_target, 32'h1FC);
    chk("addi_dest", 32'(dest_reg), 9);

    drive_r(32'h100, 32'd0, 32'd3, 5'd2);
    tick();
    chk("sll_result", alu_result, 32'h30);
    drive_r(32'h103, 32'd0, 32'h8000_0000, 5'd2);
    tick();
    chk("sra_result", alu_result, 32'hF800_0000);
    drive_r(32'h2A, 32'hFFFF_FFFF, 32'd1, 5'd2);
    tick();
    chk("slt_result", alu_result, 1);
    in_valid = 1'b0;
    tick();

    // signed mult with mfhi presented right behind it
    drive_r(32'h18, 32'hFFFF_FFFF, 32'd2, 5'd5);
    tick();
    chk("mult_busy", 32'(mdu_busy), 1);
    drive_r(32'h10, 32'd0, 32'd0, 5'd6);
    n = 0; nb = 0;
    while (!in_ready && n < 100) begin
      n++;
      if (mdu_busy) nb++;
      tick();
    end
    chk("mfhi_stall_cycles", 32'(n), 33);
    chk("mult_busy_cycles", 32'(nb), 32);
    chk("mult_retire_valid", 32'(out_valid), 1);
    chk("mult_retire_rw", 32'(reg_write_o), 0);
    chk("mult_retire_dest", 32'(dest_reg), 5);
    tick();
    chk("mfhi_value", alu_result, 32'hFFFF_FFFF);
    chk("mfhi_dest", 32'(dest_reg), 6);
    chk("mfhi_rw", 32'(reg_write_o), 1);
    in_valid = 1'b0;
    rd_chk("mflo_after_mult", 6'h12, 32'hFFFF_FFFE);

    mdu_op(6'h19, 32'hFFFF_FFFF, 32'd2);
    rd_chk("mfhi_multu", 6'h10, 32'd1);
    rd_chk("mflo_multu", 6'h12, 32'hFFFF_FFFE);

`ifdef EX_MDU_DIV_EN
    mdu_op(6'h1A, 32'hFFFF_FFF9, 32'd2);
    rd_chk("div_lo", 6'h12, 32'hFFFF_FFFD);
    rd_chk("div_hi", 6'h10, 32'hFFFF_FFFF);
    mdu_op(6'h1B, 32'd9, 32'd0);
    rd_chk("divu0_lo", 6'h12, 32'hFFFF_FFFF);
    rd_chk("divu0_hi", 6'h10, 32'd9);
    exp_hi = 32'd9; exp_lo = 32'hFFFF_FFFF;
`else
    drive_r(32'h1A, 32'hFFFF_FFF9, 32'd2, 5'd4);
    tick();
    in_valid = 1'b0;
    chk("divnop_valid", 32'(out_valid), 1);
    chk("divnop_rw", 32'(reg_write_o), 0);
    chk("divnop_busy", 32'(mdu_busy), 0);
    chk("divnop_ready", 32'(in_ready), 1);
    rd_chk("divnop_hi", 6'h10, 32'd1);
    rd_chk("divnop_lo", 6'h12, 32'hFFFF_FFFE);
    exp_hi = 32'd1; exp_lo = 32'hFFFF_FFFE;
`endif

    // downstream stall holds the output and blocks upstream
    tick();
    out_ready = 1'b0;
    drive_r(32'h20, 32'd1, 32'd2, 5'd7);
    tick();
    chk("stall_first_result", alu_result, 3);
    drive_r(32'h20, 32'd10, 32'd20, 5'd8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_result", alu_result, 3);
      chk("stall_dest", 32'(dest_reg), 7);
      chk("stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 1);
    tick();
    chk("unstall_result", alu_result, 30);
    chk("unstall_dest", 32'(dest_reg), 8);
    in_valid = 1'b0;

    // flush discards a same-cycle accept
    drive_r(32'h20, 32'd1, 32'd1, 5'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_accept_valid", 32'(out_valid), 0);
    chk("flush_accept_rw", 32'(reg_write_o), 0);

    // flush kills a held output
    drive_r(32'h20, 32'd1, 32'd1, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("held_valid", 32'(out_valid), 1);
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_held_valid", 32'(out_valid), 0);
    chk("flush_held_rw", 32'(reg_write_o), 0);

    // flush in the middle of a mult leaves HI/LO untouched
    drive_r(32'h18, 32'd3, 32'd4, 5'd5);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("flush_mid_busy_before", 32'(mdu_busy), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_mid_busy", 32'(mdu_busy), 0);
    chk("flush_mid_valid", 32'(out_valid), 0);
    chk("flush_mid_ready", 32'(in_ready), 1);
    tick();
    chk("flush_mid_valid_later", 32'(out_valid), 0);
    rd_chk("flush_mid_hi", 6'h10, exp_hi);
    rd_chk("flush_mid_lo", 6'h12, exp_lo);

    // fresh run: reset pulsed in the middle of an MDU op
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`ifdef EX_MDU_DIV_EN
    drive_r(32'h1A, 32'd100, 32'd7, 5'd3);
`else
    drive_r(32'h18, 32'd100, 32'd7, 5'd3);
`endif
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("rstmid_busy_before", 32'(mdu_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(mdu_busy), 0);
    chk("rstmid_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstmid_ready", 32'(in_ready), 1);
    rd_chk("rstmid_hi", 6'h10, 32'd0);
    rd_chk("rstmid_lo", 6'h12, 32'd0);
    tick();
    chk("rstmid_valid_end", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage with an EX/MEM output register, valid/ready handshaking on both sides, and an iterative multiply/divide unit (MDU) that owns the HI/LO registers. It sits between the ID/EX register and the memory stage. It computes the branch target, the ALU result (shamt taken from `sign_extend[10:6]`) and the destination register. Unlike the single-cycle execute stage, it back-pressures upstream while a multi-cycle MDU operation runs and holds its output while downstream stalls.

## Interface
- `XLEN`, 32: datapath width; MDU iteration count equals `XLEN`.
- `RA_W`, 5: register-address width.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: ID/EX holds a valid instruction.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `flush` input 1: kill the output register and abort the MDU.
- `reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dest` input 1 each: control bits.
- `alu_op` input 3: main-decoder ALU class; `3'b010` means R-type, decoded by funct `sign_extend[5:0]`.
- `pc_4, data1, data2, sign_extend` input `XLEN` each.
- `rt, rd` input `RA_W` each.
- `out_valid` output 1; `out_ready` input 1: downstream handshake.
- `br_target, alu_result, store_data` output `XLEN` each.
- `dest_reg` output `RA_W`.
- `zero` output 1.
- `reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o` output 1 each.
- `mdu_busy` output 1: MDU is iterating.

## Operation
- Combinational datapath:
  - `br_target = pc_4 + (sign_extend << 2)`, modulo 2^XLEN.
  - ALU B operand is `sign_extend` when `alu_src`, else `data2`.
  - `dest_reg = reg_dest ? rd : rt`.
  - `zero = (alu_result == 0)`.
- Output register:
  - Loads on accept (`in_valid && in_ready`) or on MDU completion.
  - Holds while `out_valid && !out_ready`.
  - Clears `out_valid` when it drains with nothing new to load.
- `in_ready = (state == IDLE) && (!out_valid || out_ready) && !hazard`.
  - `hazard`: mfhi (funct 0x10) or mflo (0x12) presented while `mdu_busy`.
- MDU ops: mult 0x18, multu 0x19, div 0x1A, divu 0x1B.
- FSM, state on reset = IDLE:
  - IDLE → BUSY: an MDU op is accepted. Operands are latched and the counter is set to `XLEN`. Nothing is loaded into the output register.
  - BUSY: one shift-add or restoring-subtract step per cycle. Counter decrements. → DONE when the counter reaches 1 on an edge.
  - DONE: HI/LO are written. The MDU instruction is loaded into the output register with `reg_write_o`, `mem_*_o` and `branch_o` forced to 0, when `!out_valid || out_ready`. → IDLE on that load.
- Signed ops use magnitude arithmetic with sign fix-up at DONE. Divide results: LO = quotient, HI = remainder; the remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend. No exception.
- mfhi/mflo read HI/LO as written on the latest DONE.
- `flush`:
  - Clears `out_valid` and all control outputs on the next edge.
  - In BUSY or DONE: returns to IDLE with HI/LO unchanged.
  - A same-cycle accept is discarded.
  - Flush wins over every other event.

## Timing
- Reset values: `out_valid`, all control outputs, `br_target`, `alu_result`, `store_data`, `dest_reg`, `zero`, `mdu_busy`, HI and LO are all 0.
  - `in_ready` is 1 once reset deasserts.
- Non-MDU op latency: result visible at `out_*` one cycle after the accept edge.
- MDU op accepted at edge T:
  - `mdu_busy` is 1 from T until edge T+XLEN.
  - HI/LO are updated at edge T+XLEN+1 if `out_ready`.
  - `in_ready` is 1 again from T+XLEN+1 if downstream is ready.
- mfhi issued immediately behind mult: stalls `XLEN+1` cycles, then reads the new HI.
- Downstream stall: outputs stay bit-stable while `out_valid && !out_ready`. `in_ready` is 0 during that time.
- Asserting `rst_n` low mid-MDU: returns to IDLE immediately with all registers zeroed.

## Configuration
- `EX_MDU_DIV_EN` defined: div/divu are executed as above.
- `EX_MDU_DIV_EN` undefined:
  - div/divu are treated as single-cycle no-ops: they retire in one cycle with control outputs forced 0 and HI/LO unchanged.
  - The divider datapath is not synthesised; MDU cost is the multiplier only.

## Structure
- Package `ex_pkg` holds:
  - `alu_op` class encodings, funct constants and the 4-bit ALU control codes.
  - The `mdu_state_t` enum (IDLE, BUSY, DONE).
  - The `ex_mem_t` struct for the output register.
- Sub-module `ex_mdu_iter` holds the FSM, counter, operand and accumulator registers, and HI/LO.
  - Inputs: start, op, operands, flush, drain-ready.
  - Outputs: busy, done, hi, lo.

## Test plan
- add, data1=5, data2=7, reg_dest=1, rd=3, `out_ready`=1 → next cycle `alu_result`=12, `dest_reg`=3, `zero`=0, `out_valid`=1.
- beq, sub result 0, pc_4=0x100, sign_extend=4 → `br_target`=0x110, `zero`=1, `branch_o`=1.
- mult 0xFFFFFFFF × 2, then mfhi on the next cycle → `in_ready`=0 for 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi returns 0xFFFFFFFF.
- div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 9 / 0 → LO=0xFFFFFFFF, HI=9.
- `out_ready`=0 for 4 cycles with a valid add held → outputs constant, `in_ready`=0; upstream data is taken the cycle after `out_ready` rises.
- Each of the following leaves HI/LO equal to their prior values, `out_valid`=0 and `in_ready`=1 afterwards:
  - `flush` asserted at BUSY cycle 10 of a mult.
  - A separate run with `rst_n` pulsed low mid-div.
